mouse_seg7_display: RTL and testbench

//   Downstream consumer of MouseTransceiver. Shows MouseX/MouseY as four hex digits on the

---
 rtl/mouse_seg7_display.sv | 156 +++++++++++++++
 tb/tb_mouse_seg7_display.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_seg7_display.sv
// ============================================================================
// Module      : mouse_seg7_display
// Description : Time-multiplexed 4-digit hex display of mouse X/Y. The decimal
//               points show the button state and a scroll-wheel toggle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mouse_seg7_display #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int REFRESH_HZ  = 1_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] MouseStatus,
    input  logic [7:0] MouseX,
    input  logic [7:0] MouseY,
    input  logic [7:0] MouseZ,
    output logic [3:0] SEG_SELECT,
    output logic [7:0] HEX_OUT
);

    localparam int DIV   = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("mouse_seg7_display: CLK_FREQ_HZ/REFRESH_HZ must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [1:0]       idx_q,      idx_d;
    logic             first_q,    first_d;
    logic [7:0]       x_q,        x_d;
    logic [7:0]       y_q,        y_d;
    logic [1:0]       st_q,       st_d;
    logic             dot_q,      dot_d;
    logic [7:0]       z_prev_q,   z_prev_d;
    logic             z_valid_q,  z_valid_d;
    logic [3:0]       seg_q,      seg_d;
    logic [7:0]       hex_q,      hex_d;

    logic             w_tick;
    logic             w_latch;
    logic             w_z_toggle;
    logic [3:0]       w_nib;
    logic             w_dp;
    logic             w_unused_status;

    assign w_unused_status = ^MouseStatus[3:2];

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Refresh timing and frame latch; first_q forces one latch right after reset.
    always_comb begin
        w_tick  = (cnt_q == C_CNT_LAST);
        cnt_d   = w_tick ? '0 : cnt_q + CNT_W'(1);
        idx_d   = w_tick ? idx_q + 2'd1 : idx_q;
        w_latch = w_tick && ((idx_q == 2'd3) || first_q);
        first_d = first_q & ~w_tick;
        x_d     = w_latch ? MouseX           : x_q;
        y_d     = w_latch ? MouseY           : y_q;
        st_d    = w_latch ? MouseStatus[1:0] : st_q;
    end

    // Scroll indicator: any change of MouseZ flips the dot, first clock only seeds z_prev.
    always_comb begin
        w_z_toggle = z_valid_q && (MouseZ != z_prev_q);
        dot_d      = dot_q ^ w_z_toggle;
        z_prev_d   = MouseZ;
        z_valid_d  = 1'b1;
    end

    // The digit shown after a tick uses the freshly latched frame but the pre-toggle dot.
    always_comb begin
        w_nib = 4'h0;
        w_dp  = 1'b1;
        case (idx_d)
            2'd0: begin
                w_nib = y_d[3:0];
                w_dp  = ~dot_q;
            end
            2'd1: begin
                w_nib = y_d[7:4];
                w_dp  = 1'b1;
            end
            2'd2: begin
                w_nib = x_d[3:0];
                w_dp  = ~st_d[1];
            end
            default: begin
                w_nib = x_d[7:4];
                w_dp  = ~st_d[0];
            end
        endcase
        seg_d = w_tick ? ~(4'b0001 << idx_d) : seg_q;
        hex_d = w_tick ? {w_dp, hex_seg(w_nib)} : hex_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            first_q   <= 1'b1;
            x_q       <= 8'h00;
            y_q       <= 8'h00;
            st_q      <= 2'b00;
            dot_q     <= 1'b0;
            z_prev_q  <= 8'h00;
            z_valid_q <= 1'b0;
            seg_q     <= 4'hF;
            hex_q     <= 8'hFF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            first_q   <= first_d;
            x_q       <= x_d;
            y_q       <= y_d;
            st_q      <= st_d;
            dot_q     <= dot_d;
            z_prev_q  <= z_prev_d;
            z_valid_q <= z_valid_d;
            seg_q     <= seg_d;
            hex_q     <= hex_d;
        end
    end

    assign SEG_SELECT = seg_q;
    assign HEX_OUT    = hex_q;

endmodule

`default_nettype wire

// File: tb/tb_mouse_seg7_display.sv
// ============================================================================
// Module      : tb_mouse_seg7_display
// Description : Scoreboard bench for mouse_seg7_display with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mouse_seg7_display;

    localparam int CLK_HZ = 1000;
    localparam int REF_HZ = 250;
    localparam int DIV    = CLK_HZ / REF_HZ;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] MouseStatus = 4'h0;
    logic [7:0] MouseX = 8'h00;
    logic [7:0] MouseY = 8'h00;
    logic [7:0] MouseZ = 8'h00;
    logic [3:0] SEG_SELECT;
    logic [7:0] HEX_OUT;

    mouse_seg7_display #(
        .CLK_FREQ_HZ(CLK_HZ),
        .REFRESH_HZ (REF_HZ)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MouseStatus(MouseStatus),
        .MouseX     (MouseX),
        .MouseY     (MouseY),
        .MouseZ     (MouseZ),
        .SEG_SELECT (SEG_SELECT),
        .HEX_OUT    (HEX_OUT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_q[$];
    logic [6:0]  seg_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: edge count since reset, frame snapshot, scroll dot.
    int         m_k;
    logic [7:0] m_x, m_y, m_zp;
    logic [1:0] m_st;
    logic       m_dot, m_zv;

    task automatic model_reset();
        m_k  = 0;
        m_x  = 8'h00;
        m_y  = 8'h00;
        m_st = 2'b00;
        m_dot = 1'b0;
        m_zp = 8'h00;
        m_zv = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        int         pos;
        logic [3:0] nib;
        logic       dp;
        logic [3:0] sel;
        m_k++;
        if (m_k % DIV == 0) begin
            pos = (m_k / DIV) % 4;
            if (pos == 0 || m_k == DIV) begin
                m_x  = MouseX;
                m_y  = MouseY;
                m_st = MouseStatus[1:0];
            end
            case (pos)
                0:       begin nib = m_y[3:0]; dp = ~m_dot;   end
                1:       begin nib = m_y[7:4]; dp = 1'b1;     end
                2:       begin nib = m_x[3:0]; dp = ~m_st[1]; end
                default: begin nib = m_x[7:4]; dp = ~m_st[0]; end
            endcase
            sel = 4'hF;
            sel[pos] = 1'b0;
            exp_q.push_back({sel, dp, seg_tab[nib]});
        end
        if (m_zv && MouseZ != m_zp) m_dot = ~m_dot;
        m_zp = MouseZ;
        m_zv = 1'b1;
    endtask

    // Monitor: every new strobed digit is compared with the next expected entry.
    logic [3:0]  mon_prev = 4'hF;
    int          mon_idle = 0;
    logic [11:0] mon_e;

    initial begin
        forever begin
            @(negedge CLK);
            if (SEG_SELECT != mon_prev && SEG_SELECT != 4'hF) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL digit_unexpected got seg=%b hex=%h, none expected", SEG_SELECT, HEX_OUT);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({SEG_SELECT, HEX_OUT} !== mon_e) begin
                        bad++;
                        $display("FAIL digit got seg=%b hex=%h want seg=%b hex=%h at %0t",
                                 SEG_SELECT, HEX_OUT, mon_e[11:8], mon_e[7:0], $time);
                    end
                end
                mon_idle = 0;
            end else if (exp_q.size() != 0) begin
                mon_idle++;
                if (mon_idle > 2 * DIV) begin
                    total++;
                    bad++;
                    mon_e = exp_q.pop_front();
                    $display("FAIL digit_timeout got seg=%b hex=%h want seg=%b hex=%h",
                             SEG_SELECT, HEX_OUT, mon_e[11:8], mon_e[7:0]);
                    mon_idle = 0;
                end
            end else begin
                mon_idle = 0;
            end
            mon_prev = SEG_SELECT;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            if (!RESET) model_edge();
            @(negedge CLK);
        end
    endtask

    task automatic check_blank(input string nm);
        total++;
        if (SEG_SELECT !== 4'hF || HEX_OUT !== 8'hFF) begin
            bad++;
            $display("FAIL %s got seg=%b hex=%h want seg=1111 hex=ff", nm, SEG_SELECT, HEX_OUT);
        end
    endtask

    // Called at a falling edge; reset rises between edges and must blank at once.
    task automatic do_reset(input string nm);
        #2 RESET = 1'b1;
        #1 check_blank(nm);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge CLK);
        check_blank("reset_init");
        MouseX = 8'h1E;
        MouseY = 8'h2D;
        MouseStatus = 4'h0;
        MouseZ = 8'h00;
        @(negedge CLK);
        RESET = 1'b0;

        cyc(20);
        // Frame position 1: the new X must not appear until the next wrap.
        MouseX = 8'h9F;
        cyc(20);

        MouseZ = 8'd50;
        cyc(20);
        MouseZ = 8'd254;
        cyc(1);
        MouseZ = 8'd255;
        cyc(1);
        MouseZ = 8'd0;
        cyc(20);
        cyc(20);

        MouseStatus = 4'b0001;
        cyc(20);
        MouseStatus = 4'b0010;
        cyc(20);

        MouseX = 8'hFF;
        MouseY = 8'h00;
        MouseStatus = 4'b0000;
        cyc(20);

        cyc(2);
        do_reset("reset_midframe");
        cyc(20);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) MouseX = 8'($urandom);
            if ($urandom_range(0, 7) == 0) MouseY = 8'($urandom);
            if ($urandom_range(0, 15) == 0) MouseStatus = 4'($urandom);
            case ($urandom_range(0, 5))
                0:       MouseZ = MouseZ + 8'd1;
                1:       MouseZ = MouseZ - 8'd1;
                2:       MouseZ = 8'($urandom);
                default: MouseZ = MouseZ;
            endcase
            if (i == 300) do_reset("reset_random");
            cyc(1);
        end

        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d digits pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
